// File: rtl/persistencia_temp.sv
// persistencia_temp: registers validated temperature samples, classifies them
// as BAJO/NORMAL/ALTO, counts consecutive same-band out-of-range samples and
// flags persistence; a watchdog flags a silent sensor.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   muestra_valida  - one-cycle strobe qualifying temp_muestra
//   temp_muestra    - signed 11-bit scaled sample
//   temp_registrado - last accepted sample
//   persistencia    - out-of-range held for N_MUESTRAS samples
//   banda           - 00 NORMAL, 01 BAJO, 10 ALTO
//   contador        - consecutive same-band out-of-range count
//   sensor_falla    - no valid sample for TIMEOUT_CICLOS cycles
module persistencia_temp #(
    parameter int TEMP_BAJO      = 180,
    parameter int TEMP_ALTO      = 259,
    parameter int N_MUESTRAS     = 8,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               muestra_valida,
    input  logic signed [10:0] temp_muestra,
    output logic signed [10:0] temp_registrado,
    output logic               persistencia,
    output logic [1:0]         banda,
    output logic [CNT_W-1:0]   contador,
    output logic               sensor_falla
);

    localparam int WD_W = $clog2(TIMEOUT_CICLOS + 1);

    localparam logic signed [10:0] LIM_BAJO = 11'(TEMP_BAJO);
    localparam logic signed [10:0] LIM_ALTO = 11'(TEMP_ALTO);

    localparam logic [CNT_W:0]   N_EXT  = (CNT_W + 1)'(N_MUESTRAS);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CICLOS);

    localparam logic [1:0] B_NORMAL = 2'b00;
    localparam logic [1:0] B_BAJO   = 2'b01;
    localparam logic [1:0] B_ALTO   = 2'b10;

    typedef enum logic [1:0] {
        REPOSO,
        CONTANDO,
        PERSISTE
    } estado_t;

    estado_t          state_q, state_d;
    logic [1:0]       banda_q, banda_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       clase;
    logic [CNT_W:0]   cnt_inc;
    estado_t          primer_estado;

    logic [WD_W-1:0]  wd_q, wd_d;

    // Classification: both limits are NORMAL, compare is signed.
    always_comb begin
        clase = B_NORMAL;
        if (temp_muestra < LIM_BAJO) begin
            clase = B_BAJO;
        end else if (temp_muestra > LIM_ALTO) begin
            clase = B_ALTO;
        end
    end

    // One bit wider so a count at the top of the range cannot wrap.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    // State entered by the first sample of a new out-of-range run.
    assign primer_estado = (N_EXT == (CNT_W + 1)'(1)) ? PERSISTE : CONTANDO;

    always_comb begin
        state_d = state_q;
        banda_d = banda_q;
        cnt_d   = cnt_q;
        if (muestra_valida) begin
            banda_d = clase;
            if (clase == B_NORMAL) begin
                state_d = REPOSO;
                cnt_d   = '0;
            end else if (state_q != REPOSO && clase == banda_q) begin
                if (cnt_inc >= N_EXT) begin
                    state_d = PERSISTE;
                end else begin
                    state_d = CONTANDO;
                end
                // Saturate at N_MUESTRAS once persistence is reached.
                if ({1'b0, cnt_q} < N_EXT) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end else begin
                // New run: from REPOSO or after a BAJO<->ALTO flip.
                state_d = primer_estado;
                cnt_d   = CNT_W'(1);
            end
        end
    end

    // Watchdog: cleared by every strobe, saturating otherwise.
    always_comb begin
        wd_d = wd_q;
        if (muestra_valida) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= REPOSO;
            banda_q         <= B_NORMAL;
            cnt_q           <= '0;
            temp_registrado <= '0;
            wd_q            <= '0;
            sensor_falla    <= 1'b0;
        end else begin
            state_q <= state_d;
            banda_q <= banda_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            if (muestra_valida) begin
                temp_registrado <= temp_muestra;
            end
            // A strobe always wins over a firing watchdog.
            sensor_falla <= !muestra_valida && (wd_d == WD_MAX);
        end
    end

    assign persistencia = (state_q == PERSISTE);
    assign banda        = banda_q;
    assign contador     = cnt_q;

endmodule

// File: tb/tb_persistencia_temp.sv
// tb_persistencia_temp: directed vectors with hand-computed expectations,
// checked by a scoreboard queue popped by an independent monitor.
module tb_persistencia_temp;

    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               muestra_valida;
    logic signed [10:0] temp_muestra;
    logic signed [10:0] temp_registrado;
    logic               persistencia;
    logic [1:0]         banda;
    logic [CNT_W-1:0]   contador;
    logic               sensor_falla;

    typedef struct packed {
        logic signed [10:0] temp;
        logic [1:0]         banda;
        logic [3:0]         cnt;
        logic               pers;
        logic               falla;
    } esperado_t;

    esperado_t cola[$];
    logic      chk_now = 1'b0;
    int        errors  = 0;
    int        checks  = 0;

    persistencia_temp #(
        .TEMP_BAJO(180),
        .TEMP_ALTO(259),
        .N_MUESTRAS(4),
        .CNT_W(CNT_W),
        .TIMEOUT_CICLOS(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .muestra_valida(muestra_valida),
        .temp_muestra(temp_muestra),
        .temp_registrado(temp_registrado),
        .persistencia(persistencia),
        .banda(banda),
        .contador(contador),
        .sensor_falla(sensor_falla)
    );

    always #5 clk = ~clk;

    // Monitor: after every edge flagged by the stimulus, pop and compare.
    initial begin
        esperado_t e;
        esperado_t a;
        forever begin
            @(posedge clk);
            if (chk_now) begin
                #1;
                checks++;
                a = '{temp_registrado, banda, contador,
                      persistencia, sensor_falla};
                if (cola.size() == 0) begin
                    errors++;
                    $display("FAIL chk%0d: scoreboard empty", checks);
                end else begin
                    e = cola.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL chk%0d: got t=%0d b=%b c=%0d p=%b f=%b want t=%0d b=%b c=%0d p=%b f=%b",
                                 checks, a.temp, a.banda, a.cnt, a.pers,
                                 a.falla, e.temp, e.banda, e.cnt, e.pers,
                                 e.falla);
                    end
                end
            end
        end
    end

    // One clock cycle: drive inputs, queue the expected post-edge outputs.
    task automatic v(input logic r, input logic val, input int t,
                     input int et, input logic [1:0] eb, input int ec,
                     input logic ep, input logic ef);
        esperado_t e;
        @(negedge clk);
        rst            = r;
        muestra_valida = val;
        temp_muestra   = 11'(t);
        e.temp         = 11'(et);
        e.banda        = eb;
        e.cnt          = 4'(ec);
        e.pers         = ep;
        e.falla        = ef;
        cola.push_back(e);
        chk_now        = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle(input int n, input int et, input logic [1:0] eb,
                        input int ec, input logic ep, input logic ef);
        for (int i = 0; i < n; i++) begin
            v(1'b0, 1'b0, 0, et, eb, ec, ep, ef);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        muestra_valida = 1'b0;
        temp_muestra   = '0;

        // Reset state
        v(1, 0, 0, 0, 2'b00, 0, 0, 0);
        v(1, 1, 300, 0, 2'b00, 0, 0, 0);

        // Boundaries
        v(0, 1, 179, 179, 2'b01, 1, 0, 0);
        v(0, 1, 180, 180, 2'b00, 0, 0, 0);
        v(0, 1, 259, 259, 2'b00, 0, 0, 0);
        v(0, 1, 260, 260, 2'b10, 1, 0, 0);
        v(0, 1, -5, -5, 2'b01, 1, 0, 0);

        // Persistence build-up and saturation
        v(0, 1, 300, 300, 2'b10, 1, 0, 0);
        v(0, 1, 300, 300, 2'b10, 2, 0, 0);
        v(0, 1, 300, 300, 2'b10, 3, 0, 0);
        v(0, 1, 300, 300, 2'b10, 4, 1, 0);
        v(0, 1, 300, 300, 2'b10, 4, 1, 0);
        v(0, 1, 200, 200, 2'b00, 0, 0, 0);

        // Band flip
        v(0, 1, 150, 150, 2'b01, 1, 0, 0);
        v(0, 1, 150, 150, 2'b01, 2, 0, 0);
        v(0, 1, 150, 150, 2'b01, 3, 0, 0);
        v(0, 1, 300, 300, 2'b10, 1, 0, 0);
        v(0, 1, 150, 150, 2'b01, 1, 0, 0);
        v(0, 1, 150, 150, 2'b01, 2, 0, 0);
        v(0, 1, 150, 150, 2'b01, 3, 0, 0);
        v(0, 1, 150, 150, 2'b01, 4, 1, 0);
        v(0, 1, 300, 300, 2'b10, 1, 0, 0);

        // Gaps: outputs hold between strobes
        v(0, 1, 100, 100, 2'b01, 1, 0, 0);
        idle(3, 100, 2'b01, 1, 0, 0);
        v(0, 1, 100, 100, 2'b01, 2, 0, 0);
        idle(3, 100, 2'b01, 2, 0, 0);
        v(0, 1, 100, 100, 2'b01, 3, 0, 0);
        idle(3, 100, 2'b01, 3, 0, 0);
        v(0, 1, 100, 100, 2'b01, 4, 1, 0);

        // Watchdog fires on the 10th idle cycle and holds
        idle(9, 100, 2'b01, 4, 1, 0);
        idle(2, 100, 2'b01, 4, 1, 1);
        v(0, 1, 220, 220, 2'b00, 0, 0, 0);

        // Strobe on the cycle the watchdog would fire
        idle(9, 220, 2'b00, 0, 0, 0);
        v(0, 1, 180, 180, 2'b00, 0, 0, 0);
        v(0, 0, 0, 180, 2'b00, 0, 0, 0);

        // Reset mid-count drops the concurrent sample
        v(0, 1, 400, 400, 2'b10, 1, 0, 0);
        v(0, 1, 400, 400, 2'b10, 2, 0, 0);
        v(0, 1, 400, 400, 2'b10, 3, 0, 0);
        v(1, 1, 400, 0, 2'b00, 0, 0, 0);
        v(0, 1, 400, 400, 2'b10, 1, 0, 0);

        @(negedge clk);
        chk_now        = 1'b0;
        muestra_valida = 1'b0;
        repeat (2) @(posedge clk);
        if (cola.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0",
                     cola.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
